// File: rtl/dbus_sram_responder_pkg.sv
// Shared definitions for the dbus/ibus SRAM responder: FSM encoding and the
// bus-level widths the core's request interface is built on.
package dbus_sram_responder_pkg;

  localparam int DBUS_MASK = 4;

  typedef logic [31:0] MemAddrBus;
  typedef logic [31:0] MemDataBus;

  localparam logic [1:0] RSP_IDLE = 2'd0;
  localparam logic [1:0] RSP_WAIT = 2'd1;
  localparam logic [1:0] RSP_RESP = 2'd2;

endpackage

// File: rtl/dbus_sram_responder_sram_bytemask.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module sram_bytemask #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 65536,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]         be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  // Read returns the pre-write contents; the responder never reads and writes together.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Target-side responder for the core's req/we/addr/data/mask bus: one request at
// a time, LATENCY wait states, byte-masked writes and out-of-range flagging.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    LATENCY     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    I_req,
  input  logic                    I_we,
  input  logic [ADDR_WIDTH-1:0]   I_addr,
  input  logic [DATA_WIDTH-1:0]   I_data,
  input  logic [DATA_WIDTH/8-1:0] I_mask,
  output logic [DATA_WIDTH-1:0]   O_data,
  output logic                    O_ready,
  output logic                    O_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NB-1:0]         mask_q, mask_d;
  logic                  err_q, err_d;
  logic                  rdsel_q, rdsel_d;

  logic                  idle;
  logic                  access;
  logic                  in_range;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] acc_off;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [NB-1:0]         acc_mask;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  assign idle     = (state_q == RSP_IDLE);
  assign acc_we   = idle ? I_we   : we_q;
  assign acc_addr = idle ? I_addr : addr_q;
  assign acc_data = idle ? I_data : data_q;
  assign acc_mask = idle ? I_mask : mask_q;
  assign acc_off  = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, acc_off} < SPAN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    err_d   = err_q;
    rdsel_d = rdsel_q;
    access  = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (I_req) begin
          we_d   = I_we;
          addr_d = I_addr;
          data_d = I_data;
          mask_d = I_mask;
          cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RSP_RESP;
            access  = 1'b1;
          end else begin
            state_d = RSP_WAIT;
          end
        end
      end
      RSP_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RSP_RESP;
          access  = 1'b1;
        end
      end
      RSP_RESP: begin
        state_d = RSP_IDLE;
        err_d   = 1'b0;
        rdsel_d = 1'b0;
      end
      default: state_d = RSP_IDLE;
    endcase
    if (access) begin
      err_d   = !in_range;
      rdsel_d = !acc_we && in_range;
    end
  end

  sram_bytemask #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk    (clk),
    .en_i   (access && in_range),
    .we_i   (acc_we),
    .addr_i (acc_off[AW+1:2]),
    .wdata_i(acc_data),
    .be_i   (acc_mask),
    .rdata_o(sram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      rdsel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      rdsel_q <= rdsel_d;
    end
  end

  // The SRAM read register is not reset, so read data is gated to zero outside valid reads.
  assign O_ready = (state_q == RSP_RESP);
  assign O_err   = err_q;
  assign O_data  = rdsel_q ? sram_rdata : '0;

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Synthesizable memory responder for the core's `ibus`/`dbus` request interface. It is the target-side end of the `req/we/addr/data/mask` protocol the core drives, and it replaces the DPI `pmem_read`/`pmem_write` model in SoC builds meant for synthesis or for cycle-accurate simulation. The block accepts one request at a time and models a configurable number of wait states. It applies byte-masked writes, returns registered read data with a one-cycle `O_ready` pulse, and flags out-of-range accesses.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: data width; `DATA_WIDTH/8` mask bits (= `DBUS_MASK`).
- `DEPTH_WORDS`, 65536: memory depth in words.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 1: wait states between accept and response, 0..15.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `I_req`  input  1  request valid.
- `I_we`  input  1  1 = write, 0 = read.
- `I_addr`  input  ADDR_WIDTH  byte address.
- `I_data`  input  DATA_WIDTH  write data.
- `I_mask`  input  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- `O_data`  output  DATA_WIDTH  read data; valid only while `O_ready`=1.
- `O_ready`  output  1  one-cycle response strobe.
- `O_err`  output  1  address out of range; valid only while `O_ready`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `I_req`=1: capture we/addr/data/mask, load the wait counter with `LATENCY`, and go to WAIT.
  - If `LATENCY`=0, go straight to RESP.
- WAIT: decrement the counter. At the count==1 edge, go to RESP and perform the access on that same edge.
- Access:
  - Word index = (addr − BASE_ADDR) >> 2. Address bits [1:0] are ignored.
  - In range when BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH_WORDS.
  - Read: the memory word is registered into `O_data`.
  - Write: only bytes with mask=1 are updated; `O_data` = 0.
  - Out of range: no write, `O_data` = 0, `O_err` = 1.
- RESP: `O_ready`=1 for exactly this cycle, then go to IDLE unconditionally.
- Requests are sampled only in IDLE. `I_req` is ignored in WAIT and RESP.
- Write with mask 4'b0000: completes normally, memory unchanged.

## Timing
- Reset values: state IDLE, `O_ready`=0, `O_data`=0, `O_err`=0, counter 0. Memory contents are not reset.
- Latency: request accepted at edge N → `O_ready` high during cycle N+1+`LATENCY`.
- Throughput: one transaction per `LATENCY`+2 cycles.
- Initiator rule:
  - Hold `I_req` and all request fields stable from assertion through the `O_ready` cycle inclusive.
  - Drop `I_req` or present the next request starting the cycle after `O_ready`.
  - Fields changing after acceptance have no effect, because they were captured.
- `I_req` still high in the cycle after RESP is treated as a new request.
- Reset asserted mid-transaction:
  - The transaction is dropped, with no `O_ready`.
  - A write not yet committed (state WAIT) must not modify memory.
- Read-after-write to the same word: the second transaction returns the new data.

## Structure
- Shared package (`defines.v`):
  - FSM state encoding `RSP_IDLE`/`RSP_WAIT`/`RSP_RESP`.
  - Reuse the existing `DBUS_MASK`, `MemAddrBus` and `MemDataBus`.
- Sub-module `sram_bytemask`:
  - Single-port word array with per-byte write enables and synchronous read.
  - Parameters `DATA_WIDTH`, `DEPTH_WORDS`.
  - Only ever written and read on the WAIT→RESP (or IDLE→RESP) edge.
- Top module: FSM, counter, capture registers, range check, output registers.
- Target RTL size: 150–250 lines.
- The SoC instantiates two responders (ibus tied `I_we`=0), or one shared instance behind a later arbiter.

## Test plan
- Reset, then idle 5 cycles with `I_req`=0 → `O_ready`, `O_err` and `O_data` stay 0.
- `LATENCY`=0: write 0xDEADBEEF to 0x8000_0010, mask 4'hF, then read 0x8000_0010 → `O_ready` exactly 1 cycle after each accept, read returns 0xDEADBEEF, `O_err`=0.
- `LATENCY`=3: write 0x11223344 mask 4'hF, then write 0xAABBCCDD mask 4'b0101 to 0x8000_0020, then read → `O_ready` 4 cycles after each accept, data 0x11BB33DD.
- Out of range: read 0x7FFF_FFFC and write to BASE+4·DEPTH_WORDS → `O_ready`=1, `O_err`=1, `O_data`=0; a following read of word 0 shows it unchanged.
- Hold `I_req` high continuously with `LATENCY`=1 → `O_ready` every 3 cycles, each response matching that request's address.
- Assert `rst` during WAIT of a write to 0x8000_0040 (prior value 0x0) → no `O_ready`; after release, a read returns 0x0.
